// File: rtl/pixel_write_buffer_if.sv
// rtl/pixel_write_buffer_if.sv - drawer-side and adapter-side signals of the pixel write buffer
interface pixel_write_buffer_if #(
  parameter int DEPTH       = 16,
  parameter int COLOUR_BITS = 9
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   flush;
  logic                   in_draw_enable;
  logic [7:0]             in_x;
  logic [7:0]             in_y;
  logic [23:0]            in_rgb;
  logic                   full;
  logic                   overflow;
  logic [CW-1:0]          count;
  logic                   out_ready;
  logic                   out_write_en;
  logic [7:0]             out_x;
  logic [7:0]             out_y;
  logic [COLOUR_BITS-1:0] out_colour;

  modport master (
    output flush, in_draw_enable, in_x, in_y, in_rgb, out_ready,
    input  full, overflow, count, out_write_en, out_x, out_y, out_colour
  );

  modport slave (
    input  flush, in_draw_enable, in_x, in_y, in_rgb, out_ready,
    output full, overflow, count, out_write_en, out_x, out_y, out_colour
  );
endinterface

// File: rtl/pixel_write_buffer.sv
// rtl/pixel_write_buffer.sv - FIFO between drawer bus and VGA adapter with colour reduction
// Optional off-screen clipping at the push stage with PIXEL_CLIP_EN.
module pixel_write_buffer #(
  parameter int DEPTH       = 16,
  parameter int COLOUR_BITS = 9,
  parameter int X_MAX       = 160,
  parameter int Y_MAX       = 120
) (
  input logic                clk,
  input logic                reset,
  pixel_write_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int K  = COLOUR_BITS / 3;

  typedef enum logic {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic [CW-1:0]          w_count_nxt;
  logic                   r_overflow;
  logic                   r_out_write_en;
  logic [7:0]             r_out_x;
  logic [7:0]             r_out_y;
  logic [COLOUR_BITS-1:0] r_out_colour;

  logic [7:0]             r_mem_x [DEPTH];
  logic [7:0]             r_mem_y [DEPTH];
  logic [COLOUR_BITS-1:0] r_mem_c [DEPTH];

  logic                   w_on_screen;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic [COLOUR_BITS-1:0] w_colour;
  logic                   w_unused;

  assign w_colour = {bus.in_rgb[23 -: K], bus.in_rgb[15 -: K], bus.in_rgb[7 -: K]};

`ifdef PIXEL_CLIP_EN
  assign w_on_screen = ({1'b0, bus.in_x} < 9'(X_MAX)) && ({1'b0, bus.in_y} < 9'(Y_MAX));
  assign w_unused    = ^bus.in_rgb;
`else
  assign w_on_screen = 1'b1;
  assign w_unused    = (^bus.in_rgb) ^ (X_MAX > 0) ^ (Y_MAX > 0);
`endif

  // Full comes from registered occupancy, so a pop cannot make room for a same-cycle push.
  assign w_full = (r_count == CW'(DEPTH));
  assign w_push = bus.in_draw_enable && !w_full && !bus.flush && w_on_screen;

  // DRAIN is held exactly while occupancy is non-zero, so it doubles as the not-empty flag.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_pop       = (r_state == S_DRAIN) && bus.out_ready && !bus.flush;

    if (bus.flush) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 1'b1;
    end

    if (bus.flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_count_nxt != '0) w_state_nxt = S_DRAIN;
        S_DRAIN: if (w_count_nxt == '0) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_overflow     <= 1'b0;
      r_out_write_en <= 1'b0;
      r_out_x        <= '0;
      r_out_y        <= '0;
      r_out_colour   <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_count        <= w_count_nxt;
      r_out_write_en <= w_pop;
      if (bus.in_draw_enable && w_full && w_on_screen) begin
        r_overflow <= 1'b1;
      end
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_pop) begin
        r_out_x      <= r_mem_x[r_rd_ptr];
        r_out_y      <= r_mem_y[r_rd_ptr];
        r_out_colour <= r_mem_c[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_x[r_wr_ptr] <= bus.in_x;
      r_mem_y[r_wr_ptr] <= bus.in_y;
      r_mem_c[r_wr_ptr] <= w_colour;
    end
  end

  assign bus.full         = w_full;
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.out_write_en = r_out_write_en;
  assign bus.out_x        = r_out_x;
  assign bus.out_y        = r_out_y;
  assign bus.out_colour   = r_out_colour;
endmodule

// File: tb/tb_pixel_write_buffer.sv
// tb/tb_pixel_write_buffer.sv - scoreboard bench for pixel_write_buffer
module tb_pixel_write_buffer;
  localparam int DEPTH = 16;
  localparam int CB    = 9;
  localparam int K     = CB / 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pixel_write_buffer_if #(.DEPTH(DEPTH), .COLOUR_BITS(CB)) bus();

  pixel_write_buffer #(.DEPTH(DEPTH), .COLOUR_BITS(CB), .X_MAX(160), .Y_MAX(120)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [7:0]    x;
    logic [7:0]    y;
    logic [CB-1:0] c;
  } pix_t;

  pix_t q_exp[$];
  int   occ;
  bit   m_ovf;
  bit   exp_we;
  bit   mon_en;
  int   n_tests;
  int   n_fail;

  function automatic logic [CB-1:0] conv(input logic [23:0] rgb);
    int r, g, b;
    r = int'(rgb[23:16]) >> (8 - K);
    g = int'(rgb[15:8]) >> (8 - K);
    b = int'(rgb[7:0]) >> (8 - K);
    return CB'((r << (2 * K)) | (g << K) | b);
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: accepted writes join the expected queue, pops are counted by occupancy.
  task automatic model_step();
    bit on, pop, push;
    on = 1'b1;
`ifdef PIXEL_CLIP_EN
    on = (bus.in_x < 8'd160) && (bus.in_y < 8'd120);
`endif
    pop  = (occ > 0) && bus.out_ready && !bus.flush;
    push = bus.in_draw_enable && (occ < DEPTH) && !bus.flush && on;
    if (bus.in_draw_enable && (occ == DEPTH) && on) m_ovf = 1'b1;
    exp_we = pop;
    if (bus.flush) begin
      occ = 0;
      q_exp.delete();
    end else begin
      if (push) q_exp.push_back('{x: bus.in_x, y: bus.in_y, c: conv(bus.in_rgb)});
      occ = occ + int'(push) - int'(pop);
    end
  endtask

  task automatic drive(input logic draw, input logic [7:0] x, input logic [7:0] y,
                       input logic [23:0] rgb, input logic ready, input logic fl);
    bus.in_draw_enable = draw;
    bus.in_x           = x;
    bus.in_y           = y;
    bus.in_rgb         = rgb;
    bus.out_ready      = ready;
    bus.flush          = fl;
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("count", int'(bus.count), occ);
      check("full", int'(bus.full), int'(occ == DEPTH));
      check("overflow", int'(bus.overflow), int'(m_ovf));
      check("write_en", int'(bus.out_write_en), int'(exp_we));
      if (bus.out_write_en) begin
        if (q_exp.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe: got strobe x=%0d y=%0d, expected none", bus.out_x, bus.out_y);
        end else begin
          pix_t e;
          e = q_exp.pop_front();
          check("out_x", int'(bus.out_x), int'(e.x));
          check("out_y", int'(bus.out_y), int'(e.y));
          check("out_colour", int'(bus.out_colour), int'(e.c));
        end
      end
    end
  end

  initial begin
    bus.in_draw_enable = 1'b0;
    bus.in_x           = '0;
    bus.in_y           = '0;
    bus.in_rgb         = '0;
    bus.out_ready      = 1'b0;
    bus.flush          = 1'b0;
    occ = 0; m_ovf = 1'b0; exp_we = 1'b0; mon_en = 1'b0;
    n_tests = 0; n_fail = 0;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_count", int'(bus.count), 0);
    check("rst_full", int'(bus.full), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    check("rst_write_en", int'(bus.out_write_en), 0);
    check("rst_out_x", int'(bus.out_x), 0);
    check("rst_out_colour", int'(bus.out_colour), 0);
    mon_en = 1'b1;

    // single pixel latency and colour reduction
    drive(1, 8'd5, 8'd7, 24'hFF8000, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    check("t1_write_en", int'(bus.out_write_en), 1);
    check("t1_colour", int'(bus.out_colour), int'(9'b111_100_000));
    repeat (3) drive(0, 0, 0, 0, 1, 0);

    // fill to full, overflow, then drain
    for (int i = 0; i < DEPTH; i++) drive(1, 8'(i), 8'(i + 1), 24'($urandom), 0, 0);
    check("t2_full", int'(bus.full), 1);
    check("t2_count", int'(bus.count), DEPTH);
    drive(1, 8'd99, 8'd99, 24'($urandom), 0, 0);
    check("t2_overflow", int'(bus.overflow), 1);
    check("t2_count_after", int'(bus.count), DEPTH);
    repeat (DEPTH + 4) drive(0, 0, 0, 0, 1, 0);

    // sustained streaming across pointer wrap
    for (int i = 0; i < 40; i++) begin
      drive(1, 8'($urandom_range(0, 159)), 8'($urandom_range(0, 119)), 24'($urandom), 1, 0);
      check("t3_count_le1", int'(bus.count <= 1), 1);
    end
    repeat (3) drive(0, 0, 0, 0, 1, 0);

    // flush with a same-cycle push
    for (int i = 0; i < 6; i++) drive(1, 8'(i + 20), 8'(i), 24'($urandom), 0, 0);
    drive(1, 8'd1, 8'd1, 24'($urandom), 0, 1);
    check("t4_count", int'(bus.count), 0);
    check("t4_overflow_kept", int'(bus.overflow), 1);
    repeat (5) drive(0, 0, 0, 0, 1, 0);

    // screen-edge coordinates
    drive(1, 8'd160, 8'd0, 24'h123456, 1, 0);
    drive(1, 8'd0, 8'd120, 24'hABCDEF, 1, 0);
    drive(1, 8'd159, 8'd119, 24'h00FF00, 1, 0);
    repeat (4) drive(0, 0, 0, 0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(logic'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 200)),
            8'($urandom_range(0, 150)), 24'($urandom),
            logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 49) == 0));
    end
    repeat (DEPTH + 4) drive(0, 0, 0, 0, 1, 0);

    // asynchronous reset mid-burst
    for (int i = 0; i < 4; i++) drive(1, 8'(i + 40), 8'(i + 2), 24'($urandom), 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    check("t6_we_before", int'(bus.out_write_en), 1);
    mon_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("t6_we_async", int'(bus.out_write_en), 0);
    q_exp.delete();
    occ = 0; m_ovf = 1'b0; exp_we = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    check("t6_count", int'(bus.count), 0);
    check("t6_overflow", int'(bus.overflow), 0);
    mon_en = 1'b1;
    drive(1, 8'd3, 8'd4, 24'h808080, 1, 0);
    repeat (4) drive(0, 0, 0, 0, 1, 0);

    check("sb_empty", q_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
